// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller around a combinational 32x32 signed multiplier.
// Accepts operands over in_valid/in_ready, holds them CALC_CYCLES cycles (multicycle
// budget), captures the corrected product and returns it over out_valid/out_ready.
// Ports: clk, resetn (async, active low); in_valid/in_ready/in_signed/in_x/in_y
// [/in_acc]; out_valid/out_ready/out_result; busy; hi/lo architectural registers.
// Optional macro MUL_ACC_EN: adds in_acc, accumulating the product into {hi,lo}.
module mul_ctrl #(
  parameter int CALC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
`ifdef MUL_ACC_EN
  input  logic        in_acc,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CC = (CALC_CYCLES < 1) ? 1 : CALC_CYCLES;
  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] x_q, y_q;
  logic sgn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [63:0] prod, fix, nxt;
  logic accept;
  assign accept = in_valid & in_ready;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_result = res_q;
  assign hi = res_q[63:32];
  assign lo = res_q[31:0];
  // Sign-extending both operands to 64 bits and keeping the low 64 bits of the
  // product yields the two's-complement signed product.
  assign prod = {{32{x_q[31]}}, x_q} * {{32{y_q[31]}}, y_q};
  // Unsigned correction: add back the weight lost by treating bit 31 as negative.
  assign fix = sgn_q ? prod : prod + {(x_q[31] ? y_q : 32'd0) + (y_q[31] ? x_q : 32'd0), 32'd0};
`ifdef MUL_ACC_EN
  logic acc_q;
  assign nxt = acc_q ? res_q + fix : fix;
`else
  assign nxt = fix;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CALC;
        cnt_d = CW'(CC - 1);
      end
      CALC: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else begin
        res_d = nxt;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      res_q <= '0;
      x_q <= '0;
      y_q <= '0;
      sgn_q <= 1'b0;
`ifdef MUL_ACC_EN
      acc_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      if (accept) begin
        x_q <= in_x;
        y_q <= in_y;
        sgn_q <= in_signed;
`ifdef MUL_ACC_EN
        acc_q <= in_acc;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: randomized self-checking bench for mul_ctrl against a plain-arithmetic model.
module tb_mul_ctrl;
  localparam int CC = 2;
  logic clk = 0, resetn = 0;
  logic in_valid = 0, in_ready, in_signed = 0, in_acc = 0;
  logic [31:0] in_x = 0, in_y = 0;
  logic out_valid, out_ready = 0, busy;
  logic [63:0] out_result;
  logic [31:0] hi, lo;
  int checks = 0, failures = 0;
  logic [63:0] mdl = 0;
`ifdef MUL_ACC_EN
  localparam bit ACC = 1;
`else
  localparam bit ACC = 0;
`endif

  mul_ctrl #(.CALC_CYCLES(CC)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_x(in_x), .in_y(in_y),
`ifdef MUL_ACC_EN
    .in_acc(in_acc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, y, input logic s);
    longint a, b;
    longint unsigned ua, ub;
    ua = longint'(x);
    ub = longint'(y);
    a = longint'($signed(x));
    b = longint'($signed(y));
    return s ? 64'(a * b) : 64'(ua * ub);
  endfunction

  function automatic logic [63:0] expect_op(input logic [31:0] x, y, input logic s, a);
    return ((ACC && a) ? mdl : 64'd0) + ref_prod(x, y, s);
  endfunction

  task automatic accept(input logic [31:0] x, y, input logic s, a);
    @(negedge clk);
    in_valid = 1; in_x = x; in_y = y; in_signed = s; in_acc = a;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL accept_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0; in_x = $urandom; in_y = $urandom; in_signed = 1'($urandom); in_acc = 1'($urandom);
  endtask

  task automatic wait_check(input logic [63:0] exp, input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks += 4;
    if (n != CC) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", name, n, CC); end
    if (out_result !== exp) begin failures++; $display("FAIL %s_result got=%h want=%h", name, out_result, exp); end
    if (hi !== exp[63:32]) begin failures++; $display("FAIL %s_hi got=%h want=%h", name, hi, exp[63:32]); end
    if (lo !== exp[31:0]) begin failures++; $display("FAIL %s_lo got=%h want=%h", name, lo, exp[31:0]); end
    mdl = exp;
  endtask

  task automatic release_out(input string name);
    checks += 2;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s_done_flags got=%b%b want=01", name, in_ready, busy); end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL %s_release got=%b%b want=01", name, out_valid, in_ready); end
  endtask

  task automatic run_op(input logic [31:0] x, y, input logic s, a, input logic [63:0] exp, input string name);
    accept(x, y, s, a);
    wait_check(exp, name);
    release_out(name);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (in_ready !== 1 || out_valid !== 0 || busy !== 0 || out_result !== 0 || hi !== 0 || lo !== 0) begin
      failures++; $display("FAIL reset got=%b%b%b %h want=100 0", in_ready, out_valid, busy, out_result);
    end
    @(negedge clk); resetn = 1;
  endtask

  task automatic test_vectors;
    run_op(32'hFFFFFFFF, 32'h2, 1, 0, 64'hFFFFFFFFFFFFFFFE, "s_m1x2");
    run_op(32'hFFFFFFFF, 32'h2, 0, 0, 64'h00000001FFFFFFFE, "u_m1x2");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE00000001, "u_max");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 64'h1, "s_m1m1");
    run_op(32'h80000000, 32'h80000000, 1, 0, 64'h4000000000000000, "s_min");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      logic s, a;
      x = (i % 4 == 0) ? {1'b1, 31'($urandom)} : $urandom;
      y = (i % 3 == 0) ? {1'b1, 31'($urandom)} : $urandom;
      s = 1'($urandom); a = 1'($urandom);
      run_op(x, y, s, a, expect_op(x, y, s, a), "rand");
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] held;
    run_op(32'd7, 32'hFFFFFFFD, 1, 0, 64'hFFFFFFFFFFFFFFEB, "bp_first");
    accept(32'd1234, 32'd5678, 0, 0);
    wait_check(64'd7006652, "bp_hold");
    held = out_result;
    @(negedge clk);
    in_valid = 1; in_x = 32'd9; in_y = 32'd11; in_signed = 0; in_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 0 || out_valid !== 1 || out_result !== held || {hi, lo} !== held) begin
        failures++; $display("FAIL bp_stall%0d got=%b%b %h want=01 %h", i, in_ready, out_valid, out_result, held);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0) begin failures++; $display("FAIL bp_idle got=%b%b want=10", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (busy !== 1 || in_ready !== 0) begin failures++; $display("FAIL bp_accept got=%b%b want=10", busy, in_ready); end
    wait_check(64'd99, "bp_next");
    release_out("bp_next");
  endtask

  task automatic test_reset_mid;
    accept(32'hDEADBEEF, 32'h12345678, 1, 0);
    @(posedge clk); #1;
    resetn = 0;
    #1;
    checks++;
    if (out_valid !== 0 || hi !== 0 || lo !== 0 || in_ready !== 1 || busy !== 0 || out_result !== 0) begin
      failures++; $display("FAIL rst_mid got=%b%b%b %h want=010 0", out_valid, in_ready, busy, out_result);
    end
    mdl = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 0) begin failures++; $display("FAIL rst_spurious got=%b want=0", out_valid); end
    end
    run_op(32'd3, 32'd5, 1, 0, 64'hF, "rst_after");
  endtask

  task automatic test_acc;
    run_op(32'd1, 32'hFFFFFFFF, 0, 0, 64'h00000000FFFFFFFF, "acc_seed");
    run_op(32'd1, 32'd1, 0, 1, ACC ? 64'h0000000100000000 : 64'h1, "acc_add");
  endtask

  initial begin
    fork
      begin
        test_reset;
        test_vectors;
        test_random;
        test_back_to_back;
        test_reset_mid;
        test_acc;
      end
      begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
